// File: rtl/sm2_pkg.sv
// Shared SM2 datapath constants and the modular-subtractor state encoding.
package sm2_pkg;

   localparam int unsigned SM2_WIDTH = 256;
   localparam int unsigned SM2_CHUNK = 64;

   localparam logic [255:0] SM2_P =
      256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUB  = 2'd1,
      CORR = 2'd2,
      DONE = 2'd3
   } sub_state_e;

endpackage

// File: rtl/mod_sub_seq_limb_adder.sv
// CHUNK-bit parallel-prefix (Kogge-Stone) carry-lookahead adder shared by the
// subtract and correction phases of mod_sub_seq.
module limb_adder #(
   parameter int unsigned CHUNK = 64
) (
   input  logic [CHUNK-1:0] x,
   input  logic [CHUNK-1:0] y,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout
);

   logic [CHUNK-1:0] h;
   logic [CHUNK-1:0] g_l;
   logic [CHUNK-1:0] p_l;
   logic [CHUNK-1:0] g_n;
   logic [CHUNK-1:0] p_n;
   logic [CHUNK:0]   c;

   always_comb begin
      h   = x ^ y;
      g_l = x & y;
      p_l = h;
      g_n = '0;
      p_n = '0;
      // Fold cin into bit 0 so every prefix generate is a true carry-out.
      g_l[0] = g_l[0] | (p_l[0] & cin);
      for (int d = 1; d < int'(CHUNK); d = d * 2) begin
         for (int i = 0; i < int'(CHUNK); i++) begin
            if (i >= d) begin
               g_n[i] = g_l[i] | (p_l[i] & g_l[i-d]);
               p_n[i] = p_l[i] & p_l[i-d];
            end else begin
               g_n[i] = g_l[i];
               p_n[i] = p_l[i];
            end
         end
         g_l = g_n;
         p_l = p_n;
      end
      c    = {g_l, cin};
      s    = h ^ c[CHUNK-1:0];
      cout = c[CHUNK];
   end

endmodule

// File: rtl/mod_sub_seq.sv
// Limb-serial modular subtractor: diff = (a - b) mod p, one CHUNK-bit limb per
// cycle, with a limb-serial add-back of p when the raw subtraction borrows.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// SUB   | r = a + ~b + 1, one limb per cycle
// CORR  | raw result borrowed: r = r + p, one limb per cycle
// DONE  | diff valid, held until out_ready
module mod_sub_seq
   import sm2_pkg::*;
#(
   parameter int unsigned WIDTH = SM2_WIDTH,
   parameter int unsigned CHUNK = SM2_CHUNK
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] p,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             busy
);

   localparam int unsigned N     = WIDTH / CHUNK;
   localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

   sub_state_e       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] p_q, p_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             carry_q, carry_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic             busy_q, busy_d;

   logic [CHUNK-1:0] add_x;
   logic [CHUNK-1:0] add_y;
   logic [CHUNK-1:0] add_s;
   logic             add_cout;

   // One adder serves both phases; only the operands are steered by state.
   always_comb begin
      add_x = '0;
      add_y = '0;
      if (state_q == CORR) begin
         add_x = r_q[idx_q*CHUNK +: CHUNK];
         add_y = p_q[idx_q*CHUNK +: CHUNK];
      end else begin
         add_x = a_q[idx_q*CHUNK +: CHUNK];
         add_y = ~b_q[idx_q*CHUNK +: CHUNK];
      end
   end

   limb_adder #(.CHUNK(CHUNK)) u_limb_adder (
      .x    (add_x),
      .y    (add_y),
      .cin  (carry_q),
      .s    (add_s),
      .cout (add_cout)
   );

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      p_d         = p_q;
      r_d         = r_q;
      idx_d       = idx_q;
      carry_d     = carry_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d        = a;
               b_d        = b;
               p_d        = p;
               r_d        = '0;
               idx_d      = '0;
               carry_d    = 1'b1;
               state_d    = SUB;
               in_ready_d = 1'b0;
               busy_d     = 1'b1;
            end
         end
         SUB: begin
            r_d[idx_q*CHUNK +: CHUNK] = add_s;
            carry_d = add_cout;
            idx_d   = idx_q + 1'b1;
            if (idx_q == IDX_LAST) begin
               idx_d = '0;
               if (add_cout) begin
                  state_d     = DONE;
                  busy_d      = 1'b0;
                  out_valid_d = 1'b1;
               end else begin
                  carry_d = 1'b0;
                  state_d = CORR;
               end
            end
         end
         CORR: begin
            r_d[idx_q*CHUNK +: CHUNK] = add_s;
            carry_d = add_cout;
            idx_d   = idx_q + 1'b1;
            if (idx_q == IDX_LAST) begin
               idx_d       = '0;
               carry_d     = 1'b0;
               state_d     = DONE;
               busy_d      = 1'b0;
               out_valid_d = 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
            end
         end
         default: begin
            state_d     = IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         p_q         <= '0;
         r_q         <= '0;
         idx_q       <= '0;
         carry_q     <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         p_q         <= p_d;
         r_q         <= r_d;
         idx_q       <= idx_d;
         carry_q     <= carry_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign diff      = r_q;

endmodule

// File: tb/tb_mod_sub_seq.sv
// Scoreboard bench for mod_sub_seq: directed SM2 cases, backpressure,
// mid-correction reset and a few random operand pairs.
module tb_mod_sub_seq;
   import sm2_pkg::*;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [255:0] a;
   logic [255:0] b;
   logic [255:0] p;
   logic         out_valid;
   logic         out_ready;
   logic [255:0] diff;
   logic         busy;

   int total = 0;
   int bad   = 0;
   logic [255:0] q_exp[$];

   mod_sub_seq #(.WIDTH(256), .CHUNK(64)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .p         (p),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .busy      (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] model(input logic [255:0] ma, input logic [255:0] mb,
                                          input logic [255:0] mp);
      logic [256:0] m;
      m = {1'b0, ma} - {1'b0, mb};
      if (ma < mb) m = m + {1'b0, mp};
      return m[255:0];
   endfunction

   task automatic wait_ready();
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("in_ready_wait", 256'(in_ready), 256'(1));
   endtask

   task automatic accept(input logic [255:0] ia, input logic [255:0] ib,
                         input logic [255:0] ip, input logic [255:0] exp);
      wait_ready();
      a = ia; b = ib; p = ip;
      in_valid = 1'b1;
      @(posedge clk);
      q_exp.push_back(exp);
      #1 in_valid = 1'b0;
      chk("busy_after_accept", 256'(busy), 256'(1));
   endtask

   task automatic run_op(input logic [255:0] ia, input logic [255:0] ib,
                         input logic [255:0] ip, input logic [255:0] exp, input int hold);
      int lat;
      int exp_lat;
      logic [255:0] e;
      exp_lat = (ia >= ib) ? 4 : 8;
      accept(ia, ib, ip, exp);
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", 256'(lat), 256'(exp_lat));
      if (out_valid && q_exp.size() > 0) begin
         e = q_exp.pop_front();
         chk("diff", diff, e);
         chk("busy_in_done", 256'(busy), 256'(0));
         for (int i = 0; i < hold; i++) begin
            a = ~ia; b = 256'd1; in_valid = 1'b1;
            @(posedge clk); #1;
            chk("bp_valid", 256'(out_valid), 256'(1));
            chk("bp_diff", diff, e);
            chk("bp_in_ready", 256'(in_ready), 256'(0));
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
         chk("hs_valid_drop", 256'(out_valid), 256'(0));
         chk("hs_in_ready", 256'(in_ready), 256'(1));
         chk("hs_busy", 256'(busy), 256'(0));
      end
   endtask

   initial begin
      logic [255:0] ra;
      logic [255:0] rb;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; p = '0;
      #12;
      chk("rst_in_ready", 256'(in_ready), 256'(1));
      chk("rst_out_valid", 256'(out_valid), 256'(0));
      chk("rst_busy", 256'(busy), 256'(0));
      chk("rst_diff", diff, 256'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_op(256'd5, 256'd3, SM2_P, 256'd2, 0);
      run_op(256'd3, 256'd5, SM2_P, SM2_P - 256'd2, 0);
      run_op(256'd1 << 64, 256'd1, SM2_P, 256'h0000000000000000_FFFFFFFFFFFFFFFF, 0);
      run_op(SM2_P - 256'd1, SM2_P - 256'd1, SM2_P, 256'd0, 0);
      run_op(256'd0, SM2_P - 256'd1, SM2_P, 256'd1, 0);
      run_op(256'd100, 256'd200, SM2_P, SM2_P - 256'd100, 5);

      // Reset during the second correction cycle.
      accept(256'd3, 256'd5, SM2_P, SM2_P - 256'd2);
      repeat (5) @(posedge clk);
      #2;
      chk("pre_rst_busy", 256'(busy), 256'(1));
      rst_n = 1'b0;
      #1;
      chk("mid_rst_in_ready", 256'(in_ready), 256'(1));
      chk("mid_rst_out_valid", 256'(out_valid), 256'(0));
      chk("mid_rst_busy", 256'(busy), 256'(0));
      chk("mid_rst_diff", diff, 256'd0);
      q_exp.delete();
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_op(256'd7, 256'd2, SM2_P, 256'd5, 0);

      for (int k = 0; k < 6; k++) begin
         ra = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         rb = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         ra[255] = 1'b0;
         rb[255] = 1'b0;
         run_op(ra, rb, SM2_P, model(ra, rb, SM2_P), k % 2);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
